// File: rtl/a_rom_mm_ctrl.sv
// A-matrix coefficient ROM sequencer: walks the ROM once per start, paced by x_valid,
// emitting latency-aligned MAC strobes. Define A_ROM_MM_CTRL_ABORT_EN to add the abort input.
module a_rom_mm_ctrl #(
  parameter  int ADDR_W     = 4,
  parameter  int NUM_WORDS  = 16,
  parameter  int GROUP_LEN  = 4,
  parameter  int ROM_LAT    = 1,
  localparam int NUM_GROUPS = NUM_WORDS / GROUP_LEN,
  localparam int IDX_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aload_done,
  input  logic              start,
  input  logic              x_valid,
`ifdef A_ROM_MM_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              x_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic              busy,
  output logic              done
);

  localparam int DRN_W = $clog2(ROM_LAT + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOAD,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               cnt_q, cnt_d;
  logic [DRN_W-1:0]                drn_q, drn_d;
  logic [ROM_LAT-1:0]              pipe_vld_q, pipe_vld_d;
  logic [ROM_LAT-1:0]              pipe_clr_q, pipe_clr_d;
  logic [ROM_LAT-1:0]              pipe_lst_q, pipe_lst_d;
  logic [ROM_LAT-1:0][IDX_W-1:0]   pipe_idx_q, pipe_idx_d;
  logic                            res_valid_q, res_valid_d;
  logic [IDX_W-1:0]                res_idx_q, res_idx_d;
  logic                            issue;
  logic                            out_vld;
  logic                            abort_hit;
  logic [31:0]                     addr_w;

`ifdef A_ROM_MM_CTRL_ABORT_EN
  assign abort_hit = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // An abort suppresses the strobes already leaving the pipeline in the same cycle.
  assign out_vld = pipe_vld_q[ROM_LAT-1] && !abort_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = '0;
    issue   = 1'b0;
    addr_w  = 32'(cnt_q);

    unique case (state_q)
      S_WAIT_LOAD: if (aload_done) state_d = S_IDLE;
      S_IDLE: begin
        cnt_d = '0;
        if (!aload_done)  state_d = S_WAIT_LOAD;
        else if (start)   state_d = S_RUN;
      end
      S_RUN: begin
        if (x_valid) begin
          issue = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_W'(ROM_LAT)) begin
          drn_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_WAIT_LOAD;
    endcase

    if (abort_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      drn_d   = '0;
      issue   = 1'b0;
    end
  end

  // Latency pipeline: stage 0 captures the issue, the last stage drives the MAC strobes.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_clr_d    = '0;
    pipe_lst_d    = '0;
    pipe_idx_d    = '0;
    pipe_vld_d[0] = issue;
    pipe_clr_d[0] = issue && ((addr_w % 32'(GROUP_LEN)) == 32'd0);
    pipe_lst_d[0] = issue && ((addr_w % 32'(GROUP_LEN)) == 32'(GROUP_LEN - 1));
    pipe_idx_d[0] = IDX_W'(addr_w / 32'(GROUP_LEN));
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_clr_d[i] = pipe_clr_q[i-1];
      pipe_lst_d[i] = pipe_lst_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
    if (abort_hit) begin
      pipe_vld_d = '0;
      pipe_clr_d = '0;
      pipe_lst_d = '0;
    end

    res_valid_d = out_vld && pipe_lst_q[ROM_LAT-1];
    res_idx_d   = res_valid_d ? pipe_idx_q[ROM_LAT-1] : res_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_LOAD;
      cnt_q       <= '0;
      drn_q       <= '0;
      pipe_vld_q  <= '0;
      pipe_clr_q  <= '0;
      pipe_lst_q  <= '0;
      pipe_idx_q  <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_clr_q  <= pipe_clr_d;
      pipe_lst_q  <= pipe_lst_d;
      pipe_idx_q  <= pipe_idx_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
    end
  end

  assign x_ready   = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign rom_addr  = cnt_q;
  assign mac_en    = out_vld;
  assign mac_clr   = out_vld && pipe_clr_q[ROM_LAT-1];
  assign res_valid = res_valid_q && !abort_hit;
  assign res_idx   = res_idx_q;

endmodule
